// File: rtl/csa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// csa_stream_accumulator
//   Streaming multi-operand accumulator. The running total is kept in
//   carry-save form (S, C), so each accepted operand costs one 3:2 row and no
//   carry propagation. After the last operand, S+C is resolved RES_BITS per
//   cycle through a small ripple slice. The total is then held on a
//   valid/ready output until the consumer takes it.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      accumulator accepts a beat (ACCUM state only)
//   in_data    in   WIDTH  unsigned operand
//   in_last    in   1      final beat of the transaction
//   out_valid  out  1      resolved result available (OUTPUT state)
//   out_ready  in   1      consumer takes the result
//   out_sum    out  ACC_W  resolved total mod 2^ACC_W
//   out_count  out  CW     operands accepted, saturating
//   out_ovf    out  1      sticky: more than MAX_OPS operands accepted
// -----------------------------------------------------------------------------
module csa_stream_accumulator #(
  parameter int WIDTH    = 4,
  parameter int MAX_OPS  = 16,
  parameter int RES_BITS = 2,
  localparam int ACC_W   = WIDTH + $clog2(MAX_OPS),
  localparam int CW      = $clog2(MAX_OPS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  localparam int N_RES = (ACC_W + RES_BITS - 1) / RES_BITS;
  localparam int PAD_W = N_RES * RES_BITS;
  localparam int IDX_W = (N_RES > 1) ? $clog2(N_RES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RES - 1);
  localparam logic [CW-1:0]    MAX_CNT  = CW'(MAX_OPS);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   s_acc, c_acc;
  logic [PAD_W-1:0]   result;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               cy;
  logic [IDX_W-1:0]   idx;

  logic               accept;
  logic [ACC_W-1:0]   x_ext;
  logic [ACC_W-1:0]   maj;
  logic [PAD_W-1:0]   s_pad, c_pad;
  logic [RES_BITS-1:0] s_sl, c_sl;
  logic [RES_BITS:0]  slice;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Reset forces in_ready low even though the reset state is ACCUM.
  assign in_ready  = rst_n & (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid & in_ready;

  assign out_sum   = result[ACC_W-1:0];
  assign out_count = count;
  assign out_ovf   = ovf;

  // 3:2 compression of S, C and the new operand
  assign x_ext = ACC_W'(in_data);
  assign maj   = (s_acc & c_acc) | (s_acc & x_ext) | (c_acc & x_ext);

  // Resolve slice: S and C are zero-padded to a whole number of slices
  assign s_pad = PAD_W'(s_acc);
  assign c_pad = PAD_W'(c_acc);
  assign s_sl  = s_pad[idx*RES_BITS +: RES_BITS];
  assign c_sl  = c_pad[idx*RES_BITS +: RES_BITS];
  assign slice = {1'b0, s_sl} + {1'b0, c_sl} + {{RES_BITS{1'b0}}, cy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && in_last) state_next = RESOLVE;
      RESOLVE: if (idx == LAST_IDX)   state_next = OUTPUT;
      OUTPUT:  if (out_ready)         state_next = ACCUM;
      default:                        state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_acc  <= '0;
      c_acc  <= '0;
      result <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      cy     <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s_acc <= s_acc ^ c_acc ^ x_ext;
            c_acc <= {maj[ACC_W-2:0], 1'b0};
            count <= sat_inc(count);
            // count still holds the pre-increment value: this flags beat MAX_OPS+1
            ovf   <= ovf | (count == MAX_CNT);
            if (in_last) begin
              cy  <= 1'b0;
              idx <= '0;
            end
          end
        end
        RESOLVE: begin
          result[idx*RES_BITS +: RES_BITS] <= slice[RES_BITS-1:0];
          cy  <= slice[RES_BITS];
          idx <= idx + 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            s_acc <= '0;
            c_acc <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// tb_csa_stream_accumulator
//   Directed testbench for csa_stream_accumulator (default parameters:
//   WIDTH=4, ACC_W=8, CW=5, N_RES=4). Inputs change 1 ns after the rising
//   edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_csa_stream_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [4:0] out_count;
  logic       out_ovf;

  int errors = 0;
  int checks = 0;

  csa_stream_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One beat presented for exactly one edge (in_ready is high in ACCUM).
  task automatic beat(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts edges until out_valid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 8'd0)   begin errors++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int n;
    for (int i = 0; i < 4; i++) beat(4'd15, i == 3);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_resolve got=%b exp=0", in_ready); end
    wait_out(n);
    checks++; if (n !== 4)            begin errors++; $display("FAIL basic_latency got=%0d exp=4", n); end
    checks++; if (out_sum !== 8'd60)  begin errors++; $display("FAIL basic_sum got=%0d exp=60", out_sum); end
    checks++; if (out_count !== 5'd4) begin errors++; $display("FAIL basic_count got=%0d exp=4", out_count); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    int n;
    beat(4'd9, 1'b1);
    wait_out(n);
    checks++; if (n !== 4)            begin errors++; $display("FAIL single_latency got=%0d exp=4", n); end
    checks++; if (out_sum !== 8'd9)   begin errors++; $display("FAIL single_sum got=%0d exp=9", out_sum); end
    checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", out_count); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL single_ovf got=%b exp=0", out_ovf); end
    handshake();
  endtask

  task automatic test_overflow();
    int n;
    for (int i = 0; i < 16; i++) beat(4'd15, i == 15);
    wait_out(n);
    checks++; if (out_sum !== 8'd240)  begin errors++; $display("FAIL ovf16_sum got=%0d exp=240", out_sum); end
    checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL ovf16_count got=%0d exp=16", out_count); end
    checks++; if (out_ovf !== 1'b0)    begin errors++; $display("FAIL ovf16_ovf got=%b exp=0", out_ovf); end
    handshake();
    for (int i = 0; i < 17; i++) beat(4'd15, i == 16);
    wait_out(n);
    checks++; if (out_sum !== 8'd255)  begin errors++; $display("FAIL ovf17_sum got=%0d exp=255", out_sum); end
    checks++; if (out_count !== 5'd17) begin errors++; $display("FAIL ovf17_count got=%0d exp=17", out_count); end
    checks++; if (out_ovf !== 1'b1)    begin errors++; $display("FAIL ovf17_ovf got=%b exp=1", out_ovf); end
    handshake();
  endtask

  task automatic test_backpressure();
    int n;
    beat(4'd8, 1'b0);
    beat(4'd0, 1'b0);
    beat(4'd7, 1'b1);
    wait_out(n);
    // Input pressure while the result is held must have no effect
    in_valid = 1'b1; in_data = 4'd9; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_sum !== 8'd15)  begin errors++; $display("FAIL hold_sum cyc=%0d got=%0d exp=15", i, out_sum); end
      @(posedge clk); #1;
    end
    checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL hold_count got=%0d exp=3", out_count); end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b1);
    wait_out(n);
    checks++; if (out_sum !== 8'd3)   begin errors++; $display("FAIL after_hold_sum got=%0d exp=3", out_sum); end
    checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL after_hold_count got=%0d exp=2", out_count); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int n;
    beat(4'd5, 1'b0);
    beat(4'd6, 1'b1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_sum !== 8'd0)   begin errors++; $display("FAIL midrst_sum got=%0d exp=0", out_sum); end
    checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", out_count); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid got=%b exp=0", out_valid); end
    beat(4'd3, 1'b0);
    beat(4'd4, 1'b1);
    wait_out(n);
    checks++; if (out_sum !== 8'd7)   begin errors++; $display("FAIL midrst_new_sum got=%0d exp=7", out_sum); end
    checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL midrst_new_count got=%0d exp=2", out_count); end
    handshake();
  endtask

  task automatic test_gapped();
    int n;
    beat(4'd6, 1'b0);
    // Idle with junk data/last and a stray out_ready: none of it may count
    in_data = 4'd13; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_last = 1'b0; out_ready = 1'b0;
    checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL gap_count_idle got=%0d exp=1", out_count); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL gap_in_ready got=%b exp=1", in_ready); end
    beat(4'd10, 1'b0);
    in_data = 4'd15;
    @(posedge clk); #1;
    beat(4'd1, 1'b1);
    wait_out(n);
    checks++; if (n !== 4)            begin errors++; $display("FAIL gap_latency got=%0d exp=4", n); end
    checks++; if (out_sum !== 8'd17)  begin errors++; $display("FAIL gap_sum got=%0d exp=17", out_sum); end
    checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL gap_count got=%0d exp=3", out_count); end
    checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL gap_ovf got=%b exp=0", out_ovf); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_gapped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
